// File: rtl/sdram_stub_responder.sv
// sdram_stub_responder: on-chip SDRAM stand-in answering the 16-bit as/rw/addr/data request interface.
// Latency: done pulses LATENCY cycles after the acceptance edge; reads are registered on DONE entry.
// Backpressure: ready is high only in IDLE; an as while ready=0 is dropped, never queued.
//
// Ports:
//   clk, rst_l           clock, asynchronous active-low reset
//   SDRAM_pll_locked     clock-good from initiator; low forces INIT and aborts any request
//   SDRAM_ready          idle and able to take a request this cycle
//   SDRAM_as/rw/addr     request strobe, 1=write/0=read, word address (only [ADDR_W-1:0] used)
//   SDRAM_data_write     write data
//   SDRAM_data_read      read data, valid with done after a read, held until the next read
//   SDRAM_done           one-cycle completion pulse
//
// Optional build macro SDRAM_REFRESH_EN adds periodic refresh stalls (REFRESH state).
module sdram_stub_responder #(
  parameter int ADDR_W         = 12,
  parameter int INIT_CYCLES    = 16,
  parameter int LATENCY        = 4,
  parameter int REFRESH_PERIOD = 64,
  parameter int REFRESH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        SDRAM_pll_locked,
  output logic        SDRAM_ready,
  input  logic        SDRAM_as,
  input  logic        SDRAM_rw,
  input  logic [22:0] SDRAM_addr,
  input  logic [15:0] SDRAM_data_write,
  output logic [15:0] SDRAM_data_read,
  output logic        SDRAM_done
);

  localparam logic [2:0] ST_INIT = 3'd0;
  localparam logic [2:0] ST_IDLE = 3'd1;
  localparam logic [2:0] ST_BUSY = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;

  localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);
  localparam logic [7:0]  LAT_LAST  = 8'(LATENCY - 1);

  logic [2:0]        state;
  logic [15:0]       init_cnt;
  logic [7:0]        lat_cnt;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       req_data;
  logic              refresh_take;

  // Backing store: never reset, so contents survive rst_l and pll drops.
  logic [15:0] mem [2**ADDR_W];

  // Upper address bits alias onto the array.
  logic [22-ADDR_W:0] unused_addr_hi;
  assign unused_addr_hi = SDRAM_addr[22:ADDR_W];

`ifdef SDRAM_REFRESH_EN
  localparam logic [2:0]  ST_REFRESH  = 3'd4;
  localparam logic [15:0] PERIOD_LAST = 16'(REFRESH_PERIOD - 1);
  localparam logic [7:0]  REF_LAST    = 8'(REFRESH_CYCLES - 1);

  logic [15:0] ref_period_cnt;
  logic        ref_pending;
  logic [7:0]  ref_cnt;

  // Refresh wins over a coincident as; a refresh due while BUSY/DONE waits for IDLE.
  assign refresh_take = (state == ST_IDLE) && ref_pending;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ref_period_cnt <= '0;
      ref_pending    <= 1'b0;
    end else begin
      if (refresh_take && SDRAM_pll_locked) ref_pending <= 1'b0;
      // Expiry is written last so a new period due on the take edge is not lost.
      if (ref_period_cnt == PERIOD_LAST) begin
        ref_period_cnt <= '0;
        ref_pending    <= 1'b1;
      end else begin
        ref_period_cnt <= ref_period_cnt + 16'd1;
      end
    end
  end
`else
  localparam int unused_refresh_cfg = REFRESH_PERIOD + REFRESH_CYCLES;
  assign refresh_take = 1'b0;
`endif

  // Both strobes are gated by pll_locked so a falling lock never shows a done
  // or a ready in the cycle before the FSM drops to INIT.
  assign SDRAM_ready = (state == ST_IDLE) && SDRAM_pll_locked && !refresh_take;
  assign SDRAM_done  = (state == ST_DONE) && SDRAM_pll_locked;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state           <= ST_INIT;
      init_cnt        <= '0;
      lat_cnt         <= '0;
      req_rw          <= 1'b0;
      req_addr        <= '0;
      req_data        <= '0;
      SDRAM_data_read <= '0;
`ifdef SDRAM_REFRESH_EN
      ref_cnt         <= '0;
`endif
    end else if (!SDRAM_pll_locked) begin
      // Lost clock: abort whatever is in flight and restart the init count.
      state    <= ST_INIT;
      init_cnt <= '0;
      lat_cnt  <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_cnt == INIT_LAST) begin
            state    <= ST_IDLE;
            init_cnt <= '0;
          end else begin
            init_cnt <= init_cnt + 16'd1;
          end
        end
        ST_IDLE: begin
          if (refresh_take) begin
`ifdef SDRAM_REFRESH_EN
            state   <= ST_REFRESH;
            ref_cnt <= 8'd1;
`endif
          end else if (SDRAM_as) begin
            req_rw   <= SDRAM_rw;
            req_addr <= SDRAM_addr[ADDR_W-1:0];
            req_data <= SDRAM_data_write;
            if (LATENCY == 1) begin
              // No BUSY phase: read data must be fetched on this same edge.
              state <= ST_DONE;
              if (!SDRAM_rw) SDRAM_data_read <= mem[SDRAM_addr[ADDR_W-1:0]];
            end else begin
              state   <= ST_BUSY;
              lat_cnt <= 8'd1;
            end
          end
        end
        ST_BUSY: begin
          if (lat_cnt == LAT_LAST) begin
            state   <= ST_DONE;
            lat_cnt <= '0;
            if (!req_rw) SDRAM_data_read <= mem[req_addr];
          end else begin
            lat_cnt <= lat_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
`ifdef SDRAM_REFRESH_EN
        ST_REFRESH: begin
          // The IDLE cycle that took the refresh already had ready low.
          if (ref_cnt >= REF_LAST) begin
            state   <= ST_IDLE;
            ref_cnt <= '0;
          end else begin
            ref_cnt <= ref_cnt + 8'd1;
          end
        end
`endif
        default: begin
          state    <= ST_INIT;
          init_cnt <= '0;
        end
      endcase
    end
  end

  // Writes commit on the edge leaving DONE, so a following read sees them.
  always_ff @(posedge clk) begin
    if ((state == ST_DONE) && SDRAM_pll_locked && req_rw) mem[req_addr] <= req_data;
  end

endmodule

// File: tb/tb_sdram_stub_responder.sv
// tb_sdram_stub_responder: directed bench for sdram_stub_responder (default build, ADDR_W=12, LATENCY=4).
// Latency: n/a. Backpressure: requests wait on ready with a bounded cycle budget.
// Outputs are sampled 1 time unit after each rising edge, when inputs are also driven.
module tb_sdram_stub_responder;

  localparam int ADDR_W      = 12;
  localparam int INIT_CYCLES = 16;
  localparam int LATENCY     = 4;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        pll_locked = 1'b0;
  logic        ready;
  logic        as_s = 1'b0;
  logic        rw = 1'b0;
  logic [22:0] addr = '0;
  logic [15:0] data_write = '0;
  logic [15:0] data_read;
  logic        done;

  always #5 clk = ~clk;

  sdram_stub_responder #(
    .ADDR_W(ADDR_W), .INIT_CYCLES(INIT_CYCLES), .LATENCY(LATENCY),
    .REFRESH_PERIOD(64), .REFRESH_CYCLES(4)
  ) dut (
    .clk(clk), .rst_l(rst_l), .SDRAM_pll_locked(pll_locked), .SDRAM_ready(ready),
    .SDRAM_as(as_s), .SDRAM_rw(rw), .SDRAM_addr(addr), .SDRAM_data_write(data_write),
    .SDRAM_data_read(data_read), .SDRAM_done(done)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] last_rd = 16'h0;

  typedef struct {
    logic        rw;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready && n < 100) begin
      step();
      n++;
    end
    chk({name, "_ready_wait"}, ready, 1);
  endtask

  // Steps until ready rises; returns number of edges taken (bounded).
  task automatic count_to_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic do_txn(input string name, input logic w, input logic [22:0] a,
                        input logic [15:0] wd, input logic [15:0] exp_rd);
    int n;
    wait_ready(name);
    as_s = 1'b1; rw = w; addr = a; data_write = wd;
    step();
    as_s = 1'b0;
    n = 1;
    chk({name, "_busy_ready"}, ready, 0);
    while (!done && n < 50) begin
      step();
      n++;
    end
    chk({name, "_latency"}, n, LATENCY);
    if (!w) begin
      chk({name, "_rdata"}, data_read, exp_rd);
      last_rd = exp_rd;
    end else begin
      chk({name, "_rdata_hold"}, data_read, last_rd);
    end
    step();
    chk({name, "_done_pulse"}, done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n, d1, d2, lows;
    logic seen;

    vecs[0] = '{1'b1, 23'h000005, 16'hBEEF, 16'h0};
    vecs[1] = '{1'b0, 23'h000005, 16'h0,    16'hBEEF};
    vecs[2] = '{1'b1, 23'h001001, 16'hA5A5, 16'h0};
    vecs[3] = '{1'b0, 23'h000001, 16'h0,    16'hA5A5};
    vecs[4] = '{1'b1, 23'h7FFFFF, 16'h0F0F, 16'h0};
    vecs[5] = '{1'b0, 23'h000FFF, 16'h0,    16'h0F0F};
    vecs[6] = '{1'b0, 23'h000010, 16'h0,    16'h1234};
    vecs[7] = '{1'b0, 23'h000011, 16'h0,    16'h5678};
    vecs[8] = '{1'b1, 23'h000005, 16'h1111, 16'h0};
    vecs[9] = '{1'b0, 23'h400005, 16'h0,    16'h1111};

    // Reset state
    #12;
    chk("reset_ready", ready, 0);
    chk("reset_done", done, 0);
    chk("reset_rdata", data_read, 16'h0);

    // Init count: ready exactly INIT_CYCLES edges after lock
    rst_l = 1'b1;
    pll_locked = 1'b1;
    count_to_ready(n);
    chk("init_count", n, INIT_CYCLES);

    // Lock drop in IDLE returns to INIT; drop at cycle 10 restarts count
    pll_locked = 1'b0;
    step();
    chk("unlock_ready", ready, 0);
    pll_locked = 1'b1;
    repeat (10) step();
    chk("init_midway_ready", ready, 0);
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    count_to_ready(n);
    chk("init_restart_count", n, INIT_CYCLES);

    // Manager two-beat: as held high across DONE
    wait_ready("twobeat");
    as_s = 1'b1; rw = 1'b1; addr = 23'h010; data_write = 16'h1234;
    step();
    addr = 23'h011; data_write = 16'h5678;
    n = 1; d1 = 0; d2 = 0;
    while (d2 == 0 && n < 60) begin
      if (done) begin
        if (d1 == 0) d1 = n;
        else d2 = n;
      end
      if (d2 == 0) begin
        step();
        n++;
      end
    end
    as_s = 1'b0;
    chk("twobeat_first_latency", d1, LATENCY);
    chk("twobeat_gap", d2 - d1, LATENCY + 1);
    step();
    step();

    // Table-driven transactions
    for (int i = 0; i < 10; i++)
      do_txn($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);

    // Lock drop mid-write: no done, no array write
    do_txn("abort_pre", 1'b1, 23'h020, 16'h2222, 16'h0);
    wait_ready("abort");
    as_s = 1'b1; rw = 1'b1; addr = 23'h020; data_write = 16'hFFFF;
    step();
    as_s = 1'b0;
    step();
    step();
    pll_locked = 1'b0;
    chk("abort_done_low", done, 0);
    seen = 1'b0;
    repeat (6) begin
      step();
      if (done) seen = 1'b1;
    end
    chk("abort_ready", ready, 0);
    chk("abort_no_done", seen, 0);
    pll_locked = 1'b1;
    count_to_ready(n);
    chk("abort_reinit_count", n, INIT_CYCLES);
    do_txn("abort_readback", 1'b0, 23'h020, 16'h0, 16'h2222);

    // Reset mid-BUSY: request dropped, array retained
    do_txn("rst_pre", 1'b1, 23'h030, 16'h3030, 16'h0);
    wait_ready("rst");
    as_s = 1'b1; rw = 1'b1; addr = 23'h030; data_write = 16'h3333;
    step();
    as_s = 1'b0;
    step();
    rst_l = 1'b0;
    #1;
    chk("rst_mid_ready", ready, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_rdata", data_read, 16'h0);
    last_rd = 16'h0;
    seen = 1'b0;
    repeat (3) begin
      step();
      if (done) seen = 1'b1;
    end
    rst_l = 1'b1;
    count_to_ready(n);
    chk("rst_reinit_count", n, INIT_CYCLES);
    chk("rst_no_done", seen, 0);
    do_txn("rst_readback", 1'b0, 23'h030, 16'h0, 16'h3030);

    // as while busy is ignored
    do_txn("ign_pre", 1'b1, 23'h040, 16'h0404, 16'h0);
    wait_ready("ign");
    as_s = 1'b1; rw = 1'b1; addr = 23'h050; data_write = 16'h5050;
    step();
    addr = 23'h040; data_write = 16'h4444;
    step();
    step();
    as_s = 1'b0;
    n = 3;
    while (!done && n < 50) begin
      step();
      n++;
    end
    chk("ign_latency", n, LATENCY);
    step();
    step();
    chk("ign_no_second_req", ready, 1);
    do_txn("ign_read40", 1'b0, 23'h040, 16'h0, 16'h0404);
    do_txn("ign_read50", 1'b0, 23'h050, 16'h0, 16'h5050);

    // Without refresh, ready stays high throughout IDLE
    lows = 0;
    repeat (100) begin
      if (!ready) lows++;
      step();
    end
    chk("idle_ready_continuous", lows, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
